// File: rtl/fade_multi.sv
// Multi-channel trapezoidal fade generator: shared tick prescaler and step counter,
// per-channel phase/duty ramps; optional PWM comparators built when FADE_PWM_EN is defined.
module fade_multi #(
  parameter int                    CHANNELS      = 3,
  parameter int                    PWM_INTERVAL  = 1200,
  parameter int                    TICK_INTERVAL = 12000,
  parameter int                    STEPS         = 167,
  parameter int                    STEP          = PWM_INTERVAL / STEPS,
  parameter logic [3*CHANNELS-1:0] PHASE_OFFSETS = {3'd4, 3'd2, 3'd0},
  localparam int                   W             = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic [CHANNELS*W-1:0] duty,
  output logic [CHANNELS*3-1:0] phase,
  output logic                  cycle_start,
  output logic [CHANNELS-1:0]   pwm_out
);

  localparam int TW = (TICK_INTERVAL > 1) ? $clog2(TICK_INTERVAL) : 1;
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;

  localparam logic [2:0] PH_INC   = 3'd0;
  localparam logic [2:0] PH_HIGH  = 3'd1;
  localparam logic [2:0] PH_HIGH2 = 3'd2;
  localparam logic [2:0] PH_DEC   = 3'd3;
  localparam logic [2:0] PH_LOW   = 3'd4;
  localparam logic [2:0] PH_LOW2  = 3'd5;

  localparam logic [W:0]   STEP_W   = (W+1)'(STEP);
  localparam logic [W:0]   MAX_W    = (W+1)'(PWM_INTERVAL);
  localparam logic [W-1:0] DUTY_MAX = W'(PWM_INTERVAL);

  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    case (ph)
      PH_INC:   next_phase = PH_HIGH;
      PH_HIGH:  next_phase = PH_HIGH2;
      PH_HIGH2: next_phase = PH_DEC;
      PH_DEC:   next_phase = PH_LOW;
      PH_LOW:   next_phase = PH_LOW2;
      default:  next_phase = PH_INC;
    endcase
  endfunction

  function automatic logic [W-1:0] reset_duty(input logic [2:0] ph);
    case (ph)
      PH_HIGH, PH_HIGH2, PH_DEC: reset_duty = DUTY_MAX;
      default:                   reset_duty = '0;
    endcase
  endfunction

  logic [TW-1:0] tick_cnt_r;
  logic [SW-1:0] step_cnt_r;
  logic          tick_s;
  logic          step_last_s;
  logic          cycle_start_r;

  assign tick_s      = en && (tick_cnt_r == TW'(TICK_INTERVAL - 1));
  assign step_last_s = (step_cnt_r == SW'(STEPS - 1));

  // shared prescaler and step counter; both hold while en is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_r <= '0;
      step_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
      step_cnt_r <= step_last_s ? '0 : step_cnt_r + SW'(1);
    end else if (en) begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

`ifdef FADE_PWM_EN
  logic [PW-1:0] pwm_cnt_r;

  // free-running PWM counter, unaffected by en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_r <= '0;
    end else if (pwm_cnt_r == PW'(PWM_INTERVAL - 1)) begin
      pwm_cnt_r <= '0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PW'(1);
    end
  end
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [2:0] OFF = PHASE_OFFSETS[3*i +: 3];

    if (OFF > PH_LOW2) begin : g_bad_offset
      $error("fade_multi: PHASE_OFFSETS entry exceeds 5");
    end

    logic [2:0]   phase_r;
    logic [2:0]   phase_nxt_s;
    logic [W-1:0] duty_r;
    logic [W-1:0] duty_nxt_s;
    logic [W:0]   sum_s;
    logic [W:0]   diff_s;

    // phase state register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        phase_r <= OFF;
      end else begin
        phase_r <= phase_nxt_s;
      end
    end

    // all channels advance together when the shared step counter wraps
    always_comb begin
      if (tick_s && step_last_s) begin
        phase_nxt_s = next_phase(phase_r);
      end else begin
        phase_nxt_s = phase_r;
      end
    end

    // ramp arithmetic at W+1 bits, clamped so the duty never wraps
    always_comb begin
      sum_s  = {1'b0, duty_r} + STEP_W;
      diff_s = {1'b0, duty_r} - STEP_W;
      if (tick_s) begin
        case (phase_r)
          PH_INC:            duty_nxt_s = (sum_s > MAX_W) ? DUTY_MAX : sum_s[W-1:0];
          PH_DEC:            duty_nxt_s = diff_s[W] ? '0 : diff_s[W-1:0];
          PH_HIGH, PH_HIGH2: duty_nxt_s = DUTY_MAX;
          default:           duty_nxt_s = '0;
        endcase
      end else begin
        duty_nxt_s = duty_r;
      end
    end

    // duty register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        duty_r <= reset_duty(OFF);
      end else begin
        duty_r <= duty_nxt_s;
      end
    end

    assign duty[W*i +: W]  = duty_r;
    assign phase[3*i +: 3] = phase_r;

`ifdef FADE_PWM_EN
    logic pwm_r;

    // comparator output, one clock behind counter and duty
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pwm_r <= 1'b0;
      end else begin
        pwm_r <= (W'(pwm_cnt_r) < duty_r);
      end
    end

    assign pwm_out[i] = pwm_r;
`else
    assign pwm_out[i] = 1'b0;
`endif
  end

  // pulse on the edge where channel 0 wraps from LOW2 back to INC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_start_r <= 1'b0;
    end else begin
      cycle_start_r <= tick_s && step_last_s && (g_ch[0].phase_r == PH_LOW2);
    end
  end

  assign cycle_start = cycle_start_r;

endmodule

// File: tb/tb_fade_multi.sv
// Self-checking bench for fade_multi: closed-form model of the fade envelope checked
// every cycle, plus hand-computed expectations for the directed scenarios.
module tb_fade_multi;

  localparam int CH = 3;
  localparam int PI = 16;
  localparam int TI = 4;
  localparam int ST = 4;
  localparam int W  = 5;
  localparam logic [8:0] OFFS = {3'd4, 3'd2, 3'd0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic [CH*W-1:0] duty, duty5;
  logic [CH*3-1:0] phase, phase5;
  logic            cs, cs5;
  logic [CH-1:0]   pwm, pwm5;

  int n_chk = 0;
  int n_fail = 0;

  int m_en = 0;
  int m_all = 0;
  logic m_cs = 1'b0;
  logic [CH-1:0] m_pwm = '0;
  logic [CH-1:0] m_pwm5 = '0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  fade_multi #(.CHANNELS(CH), .PWM_INTERVAL(PI), .TICK_INTERVAL(TI), .STEPS(ST),
               .STEP(4), .PHASE_OFFSETS(OFFS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .duty(duty), .phase(phase),
    .cycle_start(cs), .pwm_out(pwm));

  fade_multi #(.CHANNELS(CH), .PWM_INTERVAL(PI), .TICK_INTERVAL(TI), .STEPS(ST),
               .STEP(5), .PHASE_OFFSETS(OFFS)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .duty(duty5), .phase(phase5),
    .cycle_start(cs5), .pwm_out(pwm5));

  function automatic int off_of(int i);
    return int'(OFFS[3*i +: 3]);
  endfunction

  // phase after k ticks: one phase per ST ticks, cyclic over six phases
  function automatic int phase_at(int off, int k);
    return (off + k / ST) % 6;
  endfunction

  // duty after j ticks applied within phase p (INC starts at 0, DEC starts at full)
  function automatic int duty_in(int p, int j, int step);
    case (p)
      0:       return (j * step > PI) ? PI : j * step;
      1, 2:    return PI;
      3:       return (PI - j * step < 0) ? 0 : PI - j * step;
      default: return 0;
    endcase
  endfunction

  function automatic int model_duty(int off, int k, int step);
    if (k == 0) return (off >= 1 && off <= 3) ? PI : 0;
    if (k % ST == 0) return duty_in((phase_at(off, k) + 5) % 6, ST, step);
    return duty_in(phase_at(off, k), k % ST, step);
  endfunction

  function automatic logic [CH*W-1:0] exp_duty(int step);
    logic [CH*W-1:0] v;
    for (int i = 0; i < CH; i++) v[W*i +: W] = W'(model_duty(off_of(i), m_en / TI, step));
    return v;
  endfunction

  function automatic logic [CH*3-1:0] exp_phase();
    logic [CH*3-1:0] v;
    for (int i = 0; i < CH; i++) v[3*i +: 3] = 3'(phase_at(off_of(i), m_en / TI));
    return v;
  endfunction

  // model state: enabled edges and total edges since reset
  always @(posedge clk) begin
    if (!rst_n) begin
      m_en    <= 0;
      m_all   <= 0;
      m_cs    <= 1'b0;
      m_pwm   <= '0;
      m_pwm5  <= '0;
      m_valid <= 1'b1;
    end else begin
      if (en) m_en <= m_en + 1;
      m_all <= m_all + 1;
      m_cs  <= en && (m_en % TI == TI - 1) && (((m_en + 1) / TI) % ST == 0)
               && (phase_at(off_of(0), (m_en + 1) / TI) == 0);
      for (int i = 0; i < CH; i++) begin
        m_pwm[i]  <= (m_all % PI) < model_duty(off_of(i), m_en / TI, 4);
        m_pwm5[i] <= (m_all % PI) < model_duty(off_of(i), m_en / TI, 5);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle_check();
    logic [CH-1:0] ep, ep5;
`ifdef FADE_PWM_EN
    ep = m_pwm;
    ep5 = m_pwm5;
`else
    ep = '0;
    ep5 = '0;
`endif
    if (m_valid) begin
      chk("model_duty", duty, exp_duty(4));
      chk("model_duty_step5", duty5, exp_duty(5));
      chk("model_phase", phase, exp_phase());
      chk("model_phase_step5", phase5, exp_phase());
      chk("model_cycle_start", cs, m_cs);
      chk("model_cycle_start_step5", cs5, m_cs);
      chk("model_pwm", pwm, ep);
      chk("model_pwm_step5", pwm5, ep5);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
    cycle_check();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_duty"}, duty, {5'd0, 5'd16, 5'd0});
    chk({tag, "_phase"}, phase, {3'd4, 3'd2, 3'd0});
    chk({tag, "_cycle_start"}, cs, 1'b0);
    chk({tag, "_pwm"}, pwm, 3'b000);
  endtask

  initial begin
    int pulses;
    int hi0, hi1, hi2;
    int exp_hi0, exp_hi1;
    int inc5[4];
    int dec5[4];
    inc5 = '{5, 10, 15, 16};
    dec5 = '{11, 6, 1, 0};
`ifdef FADE_PWM_EN
    exp_hi0 = 4;
    exp_hi1 = 16;
`else
    exp_hi0 = 0;
    exp_hi1 = 0;
`endif

    // reset, then a full fade period with en held high
    rst_n = 1'b0;
    en = 1'b1;
    repeat (2) tick_clk();
    chk_reset_state("reset");
    rst_n = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 97; e++) begin
      tick_clk();
      if (cs) pulses++;
      if (e == 4) chk("ch0_first_tick", duty[4:0], 4);
      if (e == 16) begin
        chk("ch0_inc_top", duty[4:0], 16);
        chk("phase_after_16", phase, {3'd5, 3'd3, 3'd1});
      end
      if (e % 4 == 0 && e <= 16) chk("step5_inc_clamp", duty5[4:0], inc5[e/4 - 1]);
      if (e % 4 == 0 && e >= 20 && e <= 32) chk("step5_dec_clamp", duty5[9:5], dec5[e/4 - 5]);
      if (e == 96) begin
        chk("phase_wrap", phase, {3'd4, 3'd2, 3'd0});
        chk("cycle_start_at_wrap", cs, 1'b1);
      end
    end
    chk("cycle_start_pulses", pulses, 1);

    // freeze at tick count 2 for 10 clocks, then resume
    rst_n = 1'b0;
    tick_clk();
    rst_n = 1'b1;
    repeat (6) tick_clk();
    chk("ch0_before_freeze", duty[4:0], 4);
    en = 1'b0;
    repeat (10) tick_clk();
    chk("ch0_frozen", duty[4:0], 4);
    chk("phase_frozen", phase, {3'd4, 3'd2, 3'd0});
    en = 1'b1;
    tick_clk();
    chk("no_early_tick", duty[4:0], 4);
    tick_clk();
    chk("tick_after_resume", duty[4:0], 8);

    // PWM duty patterns with duties held: ch0=4, ch1=16, ch2=0
    rst_n = 1'b0;
    tick_clk();
    rst_n = 1'b1;
    repeat (4) tick_clk();
    en = 1'b0;
    hi0 = 0;
    hi1 = 0;
    hi2 = 0;
    for (int c = 0; c < 16; c++) begin
      tick_clk();
      hi0 += int'(pwm[0]);
      hi1 += int'(pwm[1]);
      hi2 += int'(pwm[2]);
    end
    chk("pwm_duty4_highs", hi0, exp_hi0);
    chk("pwm_duty16_highs", hi1, exp_hi1);
    chk("pwm_duty0_highs", hi2, 0);

    // reset mid-DEC with en low
    en = 1'b1;
    repeat (50) tick_clk();
    chk("ch0_in_dec", phase[2:0], 3);
    chk("ch0_dec_duty", duty[4:0], 12);
    en = 1'b0;
    rst_n = 1'b0;
    tick_clk();
    chk_reset_state("mid_dec_reset");
    rst_n = 1'b1;
    en = 1'b1;
    repeat (8) tick_clk();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fade_multi.md
# fade_multi

Multi-channel trapezoidal fade generator for the LED PWM path. It replaces the single-channel fade with N channels that share one prescaler, with a per-channel starting phase and a saturating ramp. An optional on-chip PWM comparator can be compiled in. It sits between the system clock and the LED pins or an external PWM stage, and produces duty levels and, optionally, PWM waveforms, e.g. three channels 120° apart for an RGB colour wheel.

## Interface
- `CHANNELS`, 3, number of independent fade channels (≥1).
- `PWM_INTERVAL`, 1200, PWM period in clocks; also the maximum duty value.
- `TICK_INTERVAL`, 12000, clocks per ramp tick (≥2).
- `STEPS`, 167, ticks spent in each phase (≥2).
- `STEP`, `PWM_INTERVAL/STEPS`, duty change per tick during ramps (≥1).
- `PHASE_OFFSETS`, `{3'd4,3'd2,3'd0}`, 3 bits per channel, channel i in bits [3i+2:3i]; reset phase of each channel. Values >5 are an elaboration `$error`.
- `clk` in 1 system clock, 12 MHz.
- `rst_n` in 1 reset; synchronous, active-low.
- `en` in 1 run enable; low freezes the tick counter, step counter, phases and duties.
- `duty` out `CHANNELS*W` per-channel duty, channel i in [W*i+W-1:W*i], where W=$clog2(PWM_INTERVAL+1).
- `phase` out `CHANNELS*3` per-channel current phase code.
- `cycle_start` out 1 one-clock pulse when channel 0 enters INC.
- `pwm_out` out `CHANNELS` per-channel PWM waveform (see Configuration).

## Operation
- Phase codes: 0 INC, 1 HIGH, 2 HIGH2, 3 DEC, 4 LOW, 5 LOW2. Sequence is 0→1→2→3→4→5→0.
- Reset, while `rst_n`=0 at a clk edge:
  - tick counter=0, step counter=0, `cycle_start`=0, `pwm_out`=0, PWM counter=0.
  - phase[i]=PHASE_OFFSETS[i].
  - duty[i]=PWM_INTERVAL for phases 1, 2, 3; otherwise 0.
- Tick counter runs 0..TICK_INTERVAL-1 and advances only when `en`=1. `tick` = `en` && count==TICK_INTERVAL-1 (internal, combinational).
- On tick, per channel, using the phase held before the edge:
  - INC: duty = min(duty+STEP, PWM_INTERVAL).
  - DEC: duty = max(duty−STEP, 0).
  - HIGH/HIGH2: duty=PWM_INTERVAL.
  - LOW/LOW2: duty=0.
- Arithmetic is done at W+1 bits before the clamp; duty never wraps.
- One step counter (0..STEPS-1) is shared by all channels and advances on tick. When it equals STEPS-1, it returns to 0 and every channel advances phase on the same edge. The duty update on that edge still uses the old phase.
- `cycle_start` is registered high for one clock on the edge where channel 0 goes 5→0.
- Full fade period = 6·STEPS·TICK_INTERVAL clocks while `en` is held high.
- Deasserting `en` mid-tick-interval holds the count. Reasserting `en` resumes from the held count with no lost or extra tick.
- Reset mid-operation restores reset values on the next edge, regardless of `en`.

## Timing
- `duty`, `phase` and `cycle_start` are registered and change on the clk edge where tick is true. They are visible one edge after the counter reaches TICK_INTERVAL-1.
- First tick after reset release occurs on the TICK_INTERVAL-th enabled edge.
- PWM counter runs 0..PWM_INTERVAL-1 continuously, independent of `en`.
- `pwm_out[i]` is registered as (pwm_cnt < duty[i]), giving one clock of latency relative to the counter and duty.
  - duty=0 gives constant low.
  - duty=PWM_INTERVAL gives constant high.
- A duty change takes effect at the compare on the next edge. No glitch-free period alignment is required.

## Configuration
- `FADE_PWM_EN` defined: PWM counter and comparators are built and `pwm_out` behaves as above.
- `FADE_PWM_EN` undefined: no PWM counter or comparators; `pwm_out` is tied to 0. `duty` is used by an external PWM stage.
- All other behaviour is identical in both builds.

## Test plan
Bench parameters: CHANNELS=3, TICK_INTERVAL=4, STEPS=4, PWM_INTERVAL=16, STEP=4, offsets {4,2,0}, `FADE_PWM_EN` defined.
1. Reset, then hold `en`=1 → duty = {0,16,0}, phase = {4,2,0}. After the 4th edge, ch0 duty=4. After 16 edges, ch0 duty=16 and phase={5,3,1}.
2. Run 96 enabled edges from reset → phases back to {4,2,0}. `cycle_start` pulses exactly once, on the edge ch0 goes 5→0.
3. Use STEP=5 (non-divisor) → ch0 INC duty sequence is 5, 10, 15, 16 (clamped). DEC is 11, 6, 1, 0 (clamped). There is no wrap.
4. Drop `en` for 10 clocks at tick count 2 → duty, phase and counters are frozen. The next tick arrives 2 enabled edges after reassertion.
5. Force ch0 duty to 4 → `pwm_out[0]` is high 4 of every 16 clocks. duty 0 gives constant low; duty 16 gives constant high.
6. Assert `rst_n`=0 for one edge mid-DEC with `en`=0 → all outputs return to reset values on that edge.
